kv_hash_store: RTL and testbench

KV_HASH_STORE -- requirements
Module: kv_hash_store

---
 rtl/kv_pkg.sv | 34 +++
 rtl/kv_hash_store_if.sv | 32 +++
 rtl/kv_hash_index.sv | 16 +
 rtl/kv_hash_store.sv | 232 +++++++++++++++++++++++
 tb/tb_kv_hash_store.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/kv_pkg.sv
// Shared encodings for the key/value hash store.
// Holds the request opcodes, transact kinds, response status codes and
// the controller FSM state encoding used by kv_hash_store and its bench.
package kv_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH   = 2'd0,
        OP_INSERT   = 2'd1,
        OP_TRANSACT = 2'd2,
        OP_DELETE   = 2'd3
    } op_e;

    typedef enum logic {
        KIND_CREDIT = 1'b0,
        KIND_DEBIT  = 1'b1
    } kind_e;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_NOT_FOUND = 3'd1,
        ST_DUPLICATE = 3'd2,
        ST_FULL      = 3'd3,
        ST_OVERFLOW  = 3'd4,
        ST_UNDERFLOW = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/kv_hash_store_if.sv
// Request/response bus of the key/value hash store.
// master: issues requests (req_*, op, transact_kind, key, value) and accepts
//         responses (resp_ready).
// slave : the store; answers with req_ready and the resp_* fields.
interface kv_hash_store_if #(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int ADDR_BITS = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           op;
    logic                 transact_kind;
    logic [KEY_W-1:0]     key;
    logic [VAL_W-1:0]     value;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [2:0]           resp_status;
    logic [VAL_W-1:0]     resp_value;
    logic [1:0]           resp_way;
    logic [ADDR_BITS-1:0] resp_index;

    modport master (
        output req_valid, op, transact_kind, key, value, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_value, resp_way, resp_index
    );

    modport slave (
        input  req_valid, op, transact_kind, key, value, resp_ready,
        output req_ready, resp_valid, resp_status, resp_value, resp_way, resp_index
    );
endinterface

// File: rtl/kv_hash_index.sv
// Per-way bucket index: (key + WAY*STRIDE) mod 2**ADDR_BITS.
// Ports: key_lo - low ADDR_BITS of the key (higher bits cannot affect the
//        result of a power-of-two modulus); idx - bucket index for this way.
module kv_hash_index #(
    parameter int ADDR_BITS = 4,
    parameter int WAY       = 0,
    parameter int STRIDE    = 7
) (
    input  logic [ADDR_BITS-1:0] key_lo,
    output logic [ADDR_BITS-1:0] idx
);
    localparam logic [ADDR_BITS-1:0] OFFSET = ADDR_BITS'(WAY * STRIDE);

    // Wrap-around of the ADDR_BITS-wide add is the modulus.
    assign idx = key_lo + OFFSET;
endmodule

// File: rtl/kv_hash_store.sv
// Multi-way hashed key/value store with SEARCH/INSERT/TRANSACT/DELETE.
// Ports: clock, reset (sync, active-high); bus (slave side of
//        kv_hash_store_if: request and response handshakes);
//        count - number of valid entries.
// Each request runs IDLE -> LOOKUP -> EXEC -> RESP; all ways are read in
// LOOKUP, EXEC decides and performs at most one entry write.
module kv_hash_store
    import kv_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int ADDR_BITS = 4,
    parameter int WAYS      = 2,
    parameter int STRIDE    = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    kv_hash_store_if.slave       bus,
    output logic [ADDR_BITS+2:0] count
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W = ADDR_BITS + 3;

    // Entry storage
    logic             valid_q [WAYS][DEPTH];
    logic [KEY_W-1:0] keys_q  [WAYS][DEPTH];
    logic [VAL_W-1:0] vals_q  [WAYS][DEPTH];

    state_e state_q, state_d;
    op_e    op_q, op_d;
    kind_e  kind_q, kind_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [VAL_W-1:0] amt_q, amt_d;

    logic                 hit_q, hit_d, free_q, free_d;
    logic [1:0]           hit_way_q, hit_way_d, free_way_q, free_way_d;
    logic [ADDR_BITS-1:0] hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;
    logic [VAL_W-1:0]     hit_val_q, hit_val_d;

    logic                 resp_valid_q, resp_valid_d;
    status_e              resp_status_q, resp_status_d;
    logic [VAL_W-1:0]     resp_value_q, resp_value_d;
    logic [1:0]           resp_way_q, resp_way_d;
    logic [ADDR_BITS-1:0] resp_index_q, resp_index_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 wr_en, wr_valid;
    logic [1:0]           wr_way;
    logic [ADDR_BITS-1:0] wr_idx;
    logic [VAL_W-1:0]     wr_val;

    logic [ADDR_BITS-1:0] idx [WAYS];
    logic [VAL_W:0]       sum;
    logic [VAL_W-1:0]     diff;

    for (genvar w = 0; w < WAYS; w++) begin : g_idx
        kv_hash_index #(.ADDR_BITS(ADDR_BITS), .WAY(w), .STRIDE(STRIDE)) u_idx (
            .key_lo (key_q[ADDR_BITS-1:0]),
            .idx    (idx[w])
        );
    end

    assign sum  = {1'b0, hit_val_q} + {1'b0, amt_q};
    assign diff = hit_val_q - amt_q;

    // Parallel probe of every way; keys are unique so the first hit is the hit.
    always_comb begin
        hit_d      = 1'b0;
        hit_way_d  = '0;
        hit_idx_d  = '0;
        hit_val_d  = '0;
        free_d     = 1'b0;
        free_way_d = '0;
        free_idx_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_d && valid_q[w][idx[w]] && keys_q[w][idx[w]] == key_q) begin
                hit_d     = 1'b1;
                hit_way_d = 2'(w);
                hit_idx_d = idx[w];
                hit_val_d = vals_q[w][idx[w]];
            end
            if (!free_d && !valid_q[w][idx[w]]) begin
                free_d     = 1'b1;
                free_way_d = 2'(w);
                free_idx_d = idx[w];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        kind_d        = kind_q;
        key_d         = key_q;
        amt_d         = amt_q;
        resp_valid_d  = resp_valid_q;
        resp_status_d = resp_status_q;
        resp_value_d  = resp_value_q;
        resp_way_d    = resp_way_q;
        resp_index_d  = resp_index_q;
        count_d       = count_q;
        wr_en         = 1'b0;
        wr_valid      = 1'b1;
        wr_way        = hit_way_q;
        wr_idx        = hit_idx_q;
        wr_val        = hit_val_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.op);
                    kind_d  = kind_e'(bus.transact_kind);
                    key_d   = bus.key;
                    amt_d   = bus.value;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_EXEC;
            S_EXEC: begin
                state_d       = S_RESP;
                resp_valid_d  = 1'b1;
                resp_status_d = ST_NOT_FOUND;
                resp_value_d  = '0;
                resp_way_d    = '0;
                resp_index_d  = '0;
                case (op_q)
                    OP_SEARCH: if (hit_q) resp_status_d = ST_OK;
                    OP_INSERT: begin
                        if (hit_q)       resp_status_d = ST_DUPLICATE;
                        else if (free_q) begin
                            resp_status_d = ST_OK;
                            wr_en   = 1'b1;
                            wr_way  = free_way_q;
                            wr_idx  = free_idx_q;
                            wr_val  = amt_q;
                            count_d = count_q + CNT_W'(1);
                        end else         resp_status_d = ST_FULL;
                    end
                    OP_TRANSACT: begin
                        if (hit_q) begin
                            if (kind_q == KIND_CREDIT) begin
                                resp_status_d = sum[VAL_W] ? ST_OVERFLOW : ST_OK;
                                wr_val        = sum[VAL_W-1:0];
                            end else begin
                                resp_status_d = (amt_q > hit_val_q) ? ST_UNDERFLOW : ST_OK;
                                wr_val        = diff;
                            end
                            wr_en = (resp_status_d == ST_OK);
                        end
                    end
                    default: begin // OP_DELETE
                        if (hit_q) begin
                            resp_status_d = ST_OK;
                            wr_en    = 1'b1;
                            wr_valid = 1'b0;
                            count_d  = count_q - CNT_W'(1);
                        end
                    end
                endcase
                // OK responses report the value now stored (old value for DELETE).
                if (resp_status_d == ST_OK) begin
                    resp_value_d = (wr_en && wr_valid) ? wr_val : hit_val_q;
                    resp_way_d   = wr_en ? wr_way : hit_way_q;
                    resp_index_d = wr_en ? wr_idx : hit_idx_q;
                end
            end
            default: begin // S_RESP
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            resp_valid_q  <= 1'b0;
            resp_status_q <= ST_OK;
            resp_value_q  <= '0;
            resp_way_q    <= '0;
            resp_index_q  <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_value_q  <= resp_value_d;
            resp_way_q    <= resp_way_d;
            resp_index_q  <= resp_index_d;
            count_q       <= count_d;
        end
    end

    // Request and probe registers carry data only; no reset needed.
    always_ff @(posedge clock) begin
        op_q       <= op_d;
        kind_q     <= kind_d;
        key_q      <= key_d;
        amt_q      <= amt_d;
        if (state_q == S_LOOKUP) begin
            hit_q      <= hit_d;
            hit_way_q  <= hit_way_d;
            hit_idx_q  <= hit_idx_d;
            hit_val_q  <= hit_val_d;
            free_q     <= free_d;
            free_way_q <= free_way_d;
            free_idx_q <= free_idx_d;
        end
    end

    // Reset wins over an EXEC-cycle write so an interrupted request leaves no trace.
    always_ff @(posedge clock) begin
        for (int w = 0; w < WAYS; w++) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) valid_q[w][i] <= 1'b0;
            end else if (wr_en && wr_way == 2'(w)) begin
                valid_q[w][wr_idx] <= wr_valid;
                keys_q[w][wr_idx]  <= key_q;
                vals_q[w][wr_idx]  <= wr_val;
            end
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_status = resp_status_q;
    assign bus.resp_value  = resp_value_q;
    assign bus.resp_way    = resp_way_q;
    assign bus.resp_index  = resp_index_q;
    assign count           = count_q;
endmodule

// File: tb/tb_kv_hash_store.sv
module tb_kv_hash_store;
    import kv_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] count;
    int         n_tests = 0;
    int         n_fail  = 0;

    kv_hash_store_if #(.KEY_W(32), .VAL_W(32), .ADDR_BITS(4)) bus ();

    kv_hash_store #(.KEY_W(32), .VAL_W(32), .ADDR_BITS(4), .WAYS(2), .STRIDE(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    logic [2:0]  r_st;
    logic [31:0] r_val;
    logic [1:0]  r_way;
    logic [3:0]  r_idx;

    // Issue one request and collect its response; hold keeps resp_ready low
    // for that many cycles while checking the response stays put.
    task automatic txn(input string tag, input logic [1:0] o, input logic k,
                       input logic [31:0] ky, input logic [31:0] v, input int hold);
        int n;
        @(negedge clock);
        bus.req_valid     = 1'b1;
        bus.op            = o;
        bus.transact_kind = k;
        bus.key           = ky;
        bus.value         = v;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 10) begin
            @(posedge clock);
            #1 n++;
        end
        chk({tag, "_latency"}, n, 2);
        r_st  = bus.resp_status;
        r_val = bus.resp_value;
        r_way = bus.resp_way;
        r_idx = bus.resp_index;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1;
            chk({tag, "_hold_valid"}, bus.resp_valid, 1);
            chk({tag, "_hold_stat"}, bus.resp_status, r_st);
            chk({tag, "_hold_val"}, bus.resp_value, r_val);
            chk({tag, "_hold_idx"}, {bus.resp_way, bus.resp_index}, {r_way, r_idx});
            chk({tag, "_hold_rdy"}, bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.req_valid     = 1'b0;
        bus.op            = '0;
        bus.transact_kind = 1'b0;
        bus.key           = '0;
        bus.value         = '0;
        bus.resp_ready    = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst_count", count, 0);
        chk("rst_rvalid", bus.resp_valid, 0);
        chk("rst_status", bus.resp_status, 0);
        chk("rst_value", bus.resp_value, 0);
        chk("rst_wayidx", {bus.resp_way, bus.resp_index}, 0);
        chk("rst_rdy", bus.req_ready, 1);

        txn("ins524", OP_INSERT, 1'b0, 524, 3423, 0);
        chk("ins524_st", r_st, ST_OK);
        chk("ins524_way", r_way, 0);
        chk("ins524_idx", r_idx, 12);
        chk("ins524_cnt", count, 1);
        txn("srch524", OP_SEARCH, 1'b0, 524, 0, 0);
        chk("srch524_st", r_st, ST_OK);
        chk("srch524_val", r_val, 3423);
        chk("srch524_wi", {r_way, r_idx}, {2'd0, 4'd12});
        txn("srch279", OP_SEARCH, 1'b0, 279, 0, 0);
        chk("srch279_st", r_st, ST_NOT_FOUND);
        chk("srch279_val", r_val, 0);
        chk("srch279_wi", {r_way, r_idx}, 0);

        txn("dup524", OP_INSERT, 1'b0, 524, 77, 0);
        chk("dup524_st", r_st, ST_DUPLICATE);
        chk("dup524_wi", {r_way, r_idx}, 0);
        txn("ins540", OP_INSERT, 1'b0, 540, 11, 0);
        chk("ins540_st", r_st, ST_OK);
        chk("ins540_way", r_way, 1);
        chk("ins540_idx", r_idx, 3);
        txn("ins556f", OP_INSERT, 1'b0, 556, 22, 0);
        chk("ins556f_st", r_st, ST_FULL);
        chk("ins556f_wi", {r_way, r_idx}, 0);
        chk("ins556f_cnt", count, 2);

        txn("deb", OP_TRANSACT, KIND_DEBIT, 524, 3424, 0);
        chk("deb_st", r_st, ST_UNDERFLOW);
        chk("deb_wi", {r_way, r_idx}, 0);
        txn("cred", OP_TRANSACT, KIND_CREDIT, 524, 100, 0);
        chk("cred_st", r_st, ST_OK);
        chk("cred_val", r_val, 3523);
        txn("ovf", OP_TRANSACT, KIND_CREDIT, 524, 32'hFFFF_FFF0, 0);
        chk("ovf_st", r_st, ST_OVERFLOW);
        txn("deb1", OP_TRANSACT, KIND_DEBIT, 540, 11, 0);
        chk("deb1_st", r_st, ST_OK);
        chk("deb1_val", r_val, 0);
        txn("tx_abs", OP_TRANSACT, KIND_CREDIT, 279, 5, 0);
        chk("tx_abs_st", r_st, ST_NOT_FOUND);

        txn("del524", OP_DELETE, 1'b0, 524, 0, 0);
        chk("del524_st", r_st, ST_OK);
        chk("del524_val", r_val, 3523);
        chk("del524_cnt", count, 1);
        txn("del_abs", OP_DELETE, 1'b0, 524, 0, 0);
        chk("del_abs_st", r_st, ST_NOT_FOUND);
        txn("srchdel", OP_SEARCH, 1'b0, 524, 0, 0);
        chk("srchdel_st", r_st, ST_NOT_FOUND);
        txn("ins556", OP_INSERT, 1'b0, 556, 22, 0);
        chk("ins556_st", r_st, ST_OK);
        chk("ins556_wi", {r_way, r_idx}, {2'd0, 4'd12});
        chk("ins556_cnt", count, 2);

        txn("hold", OP_SEARCH, 1'b0, 556, 0, 5);
        chk("hold_st", r_st, ST_OK);
        chk("hold_val", r_val, 22);

        // Reset pulse landing on the EXEC cycle of an INSERT.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.op        = OP_INSERT;
        bus.key       = 300;
        bus.value     = 9;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        chk("mid_rst_rvalid", bus.resp_valid, 0);
        chk("mid_rst_cnt", count, 0);
        chk("mid_rst_rdy", bus.req_ready, 1);
        repeat (4) @(posedge clock);
        #1 chk("mid_rst_norsp", bus.resp_valid, 0);
        txn("srch300", OP_SEARCH, 1'b0, 300, 0, 0);
        chk("srch300_st", r_st, ST_NOT_FOUND);
        txn("srch556r", OP_SEARCH, 1'b0, 556, 0, 0);
        chk("srch556r_st", r_st, ST_NOT_FOUND);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
